// File: rtl/i2c_spi_pkg.sv
// i2c_spi_pkg: register map, opcodes, bit indices and FSM states shared by the I2C-to-SPI sequencer
package i2c_spi_pkg;
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_DIV  = 3'd1;
  localparam logic [2:0] REG_TX   = 3'd2;
  localparam logic [2:0] REG_RX   = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;
  localparam logic [1:0] OP_XFER = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam int CTRL_GO   = 0;
  localparam int STAT_BUSY = 0;
  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_HDR, S_DIV_GET, S_DIV_WR, S_TX_GET, S_TX_WR,
    S_GO_WR, S_POLL, S_RX_RD, S_RSP, S_CS_OFF, S_DRAIN
  } state_e;
endpackage

// File: rtl/i2c_spi_wb_xact.sv
// i2c_spi_wb_xact: single-access Wishbone classic master; one req becomes one bus cycle, done pulses after ack
module i2c_spi_wb_xact #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [7:0]    wdat_i,
  output logic          done_o,
  output logic [7:0]    rdat_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [7:0]    wb_dat_o,
  input  logic [7:0]    wb_dat_i,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i
);
  logic          cyc_q, we_q, done_q;
  logic [AW-1:0] adr_q;
  logic [7:0]    dat_q, rdat_q;
  // done_q blocks a new start so the requester sees one idle cycle between accesses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (cyc_q && wb_ack_i) begin
        cyc_q  <= 1'b0;
        done_q <= 1'b1;
        rdat_q <= wb_dat_i;
      end else if (!cyc_q && !done_q && req_i) begin
        cyc_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= wdat_i;
      end
    end
  assign done_o   = done_q;
  assign rdat_o   = rdat_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_sel_o = {3'b000, cyc_q};
endmodule

// File: rtl/i2c_spi_xfer_sequencer.sv
// i2c_spi_xfer_sequencer: runs SPI transfers requested over I2C by driving the SPI core's Wishbone registers
// Define SPI_SEQ_TIMEOUT_EN to abort a byte after POLL_MAX busy STAT reads.
module i2c_spi_xfer_sequencer
  import i2c_spi_pkg::*;
#(
  parameter int         WB_AW       = 3,
  parameter logic [7:0] DEFAULT_DIV = 8'd4,
  parameter int         POLL_MAX    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cmd_byte_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  output logic [7:0]       rsp_byte_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WB_AW-1:0] wb_adr_o,
  output logic [7:0]       wb_dat_o,
  input  logic [7:0]       wb_dat_i,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  output logic             ss_n_o,
  output logic             busy_o,
  output logic             err_o
);
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [7:0]       poll_q, poll_d, byte_q, rsp_q, wdat, rdat;
  logic             err_q, err_d, rdy_q, vld_q, ss_q, busy_q;
  logic             req, we, done, cmd_hs, rsp_hs, stat_busy, poll_to;
  logic [WB_AW-1:0] adr;
  assign cmd_hs    = cmd_valid_i && rdy_q;
  assign rsp_hs    = vld_q && rsp_ready_i;
  assign stat_busy = rdat[STAT_BUSY];
  assign poll_to   = TO_EN && stat_busy && (poll_q == 8'(POLL_MAX - 1));
  assign req  = state_q inside {S_INIT, S_DIV_WR, S_TX_WR, S_GO_WR, S_POLL, S_RX_RD};
  assign we   = state_q inside {S_INIT, S_DIV_WR, S_TX_WR, S_GO_WR};
  assign adr  = state_q == S_GO_WR ? WB_AW'(REG_CTRL) :
                state_q == S_TX_WR ? WB_AW'(REG_TX)   :
                state_q == S_POLL  ? WB_AW'(REG_STAT) :
                state_q == S_RX_RD ? WB_AW'(REG_RX)   : WB_AW'(REG_DIV);
  assign wdat = state_q == S_INIT  ? DEFAULT_DIV :
                state_q == S_GO_WR ? 8'(1 << CTRL_GO) : byte_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    err_d   = err_q;
    case (state_q)
      S_INIT:    if (done) state_d = S_IDLE;
      S_IDLE:    if (cmd_hs) state_d = S_HDR;
      S_HDR: begin
        cnt_d   = byte_q[5:0];
        err_d   = err_q | byte_q[7];
        state_d = byte_q[7:6] == OP_XFER ? (byte_q[5:0] == 6'd0 ? S_IDLE : S_TX_GET) :
                  byte_q[7:6] == OP_DIV  ? S_DIV_GET : S_IDLE;
      end
      S_DIV_GET: if (cmd_hs) state_d = S_DIV_WR;
      S_DIV_WR:  if (done) state_d = S_IDLE;
      S_TX_GET: if (cmd_hs) begin
        state_d = S_TX_WR;
        cnt_d   = cnt_q - 6'd1;
      end
      S_TX_WR:   if (done) state_d = S_GO_WR;
      S_GO_WR: if (done) begin
        state_d = S_POLL;
        poll_d  = '0;
      end
      S_POLL: if (done) begin
        poll_d  = poll_q + 8'd1;
        err_d   = err_q | poll_to;
        state_d = !stat_busy ? S_RX_RD : poll_to ? S_CS_OFF : S_POLL;
      end
      S_RX_RD:   if (done) state_d = S_RSP;
      S_RSP:     if (rsp_hs) state_d = cnt_q == 6'd0 ? S_CS_OFF : S_TX_GET;
      // bytes left after a timeout are still owed by the I2C side and get swallowed
      S_CS_OFF:  state_d = cnt_q == 6'd0 ? S_IDLE : S_DRAIN;
      S_DRAIN: if (cmd_hs) begin
        cnt_d   = cnt_q - 6'd1;
        state_d = cnt_q == 6'd1 ? S_IDLE : S_DRAIN;
      end
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      poll_q  <= '0;
      err_q   <= 1'b0;
      byte_q  <= '0;
      rsp_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      if (cmd_hs) byte_q <= cmd_byte_i;
      if (state_q == S_RX_RD && done) rsp_q <= rdat;
      rdy_q   <= state_d inside {S_IDLE, S_DIV_GET, S_TX_GET, S_DRAIN};
      vld_q   <= state_d == S_RSP;
      ss_q    <= !(state_d inside {S_TX_GET, S_TX_WR, S_GO_WR, S_POLL, S_RX_RD, S_RSP});
      busy_q  <= state_d != S_IDLE;
    end
  i2c_spi_wb_xact #(.AW(WB_AW)) u_xact (
    .clk(clk), .rst_n(rst_n),
    .req_i(req), .we_i(we), .adr_i(adr), .wdat_i(wdat),
    .done_o(done), .rdat_o(rdat),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );
  assign cmd_ready_o = rdy_q;
  assign rsp_byte_o  = rsp_q;
  assign rsp_valid_o = vld_q;
  assign ss_n_o      = ss_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
endmodule
